// File: rtl/seg_defs_pkg.sv
// ----------------------------------------------------------------------------
// seg_defs
//   Shared 7-segment definitions: active-high a..g patterns for the hex digits
//   0..F and the bit positions of each segment within the 8-bit segment bus
//   {dp, a, b, c, d, e, f, g}.
// ----------------------------------------------------------------------------
package seg_defs;

    // Seven segments a..g, a in bit 6 down to g in bit 0, 1 = lit.
    typedef logic [6:0] seg7_t;

    // Bit positions on the 8-bit segment bus.
    localparam int SEG_DP = 7;
    localparam int SEG_A  = 6;
    localparam int SEG_B  = 5;
    localparam int SEG_C  = 4;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 2;
    localparam int SEG_F  = 1;
    localparam int SEG_G  = 0;

    // Hex glyphs (lower-case b and d so they are distinct from 8 and 0).
    localparam seg7_t SEG_0 = 7'h7E;
    localparam seg7_t SEG_1 = 7'h30;
    localparam seg7_t SEG_2 = 7'h6D;
    localparam seg7_t SEG_3 = 7'h79;
    localparam seg7_t SEG_4 = 7'h33;
    localparam seg7_t SEG_5 = 7'h5B;
    localparam seg7_t SEG_6 = 7'h5F;
    localparam seg7_t SEG_7 = 7'h70;
    localparam seg7_t SEG_8 = 7'h7F;
    localparam seg7_t SEG_9 = 7'h7B;
    localparam seg7_t SEG_A_HEX = 7'h77;
    localparam seg7_t SEG_B_HEX = 7'h1F;
    localparam seg7_t SEG_C_HEX = 7'h4E;
    localparam seg7_t SEG_D_HEX = 7'h3D;
    localparam seg7_t SEG_E_HEX = 7'h4F;
    localparam seg7_t SEG_F_HEX = 7'h47;

endpackage

// File: rtl/seg_hex_decode.sv
// ----------------------------------------------------------------------------
// seg_hex_decode
//   Combinational hex-nibble to 7-segment decoder, active-high a..g.
//   Ports:
//     nibble  in   4   hex value 0..F
//     segs    out  7   {a, b, c, d, e, f, g}, 1 = segment lit
// ----------------------------------------------------------------------------
module seg_hex_decode
    import seg_defs::*;
(
    input  logic [3:0] nibble,
    output seg7_t      segs
);

    // NOTE: every signal written in an always_comb gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        segs = SEG_0;
        case (nibble)
            4'h0: segs = SEG_0;
            4'h1: segs = SEG_1;
            4'h2: segs = SEG_2;
            4'h3: segs = SEG_3;
            4'h4: segs = SEG_4;
            4'h5: segs = SEG_5;
            4'h6: segs = SEG_6;
            4'h7: segs = SEG_7;
            4'h8: segs = SEG_8;
            4'h9: segs = SEG_9;
            4'hA: segs = SEG_A_HEX;
            4'hB: segs = SEG_B_HEX;
            4'hC: segs = SEG_C_HEX;
            4'hD: segs = SEG_D_HEX;
            4'hE: segs = SEG_E_HEX;
            4'hF: segs = SEG_F_HEX;
            default: segs = SEG_0;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// ----------------------------------------------------------------------------
// seg_scan_driver
//   Time-multiplexed DIGITS-digit 7-segment driver with per-digit dot/blank,
//   leading-zero suppression, PWM brightness and frame-latched inputs.
//   Ports:
//     clk         in   1           system clock
//     reset       in   1           synchronous, active-high reset
//     data        in   4*DIGITS    hex nibbles, digit k = data[4k+3:4k], digit 0 rightmost
//     dots        in   DIGITS      decimal point for digit k
//     blank       in   DIGITS      force digit k fully dark
//     lzs         in   1           leading-zero suppression enable
//     brightness  in   BRIGHT_W    0 = dimmest, all-ones = full on (sampled live)
//     seg         out  8           {dp, a, b, c, d, e, f, g}
//     an          out  DIGITS      one-hot digit enable
//     frame_tick  out  1           one-cycle pulse at the start of each frame
// ----------------------------------------------------------------------------
module seg_scan_driver
    import seg_defs::*;
#(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BRIGHT_W   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dots,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lzs,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DIG_W = $clog2(DIGITS);
    localparam int LIM_W = BRIGHT_W + 32;

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(CLK_DIV - 1);
    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(DIGITS - 1);

    // XOR mask applied at the output registers; all internal logic is active-high.
    localparam logic POL = (ACTIVE_LOW != 0);

    // ------------------------------------------------------------------
    // Prescaler and digit counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] pre_cnt;
    logic [DIG_W-1:0] digit;
    logic             frame_start;

    assign frame_start = (pre_cnt == '0) && (digit == '0);

    // NOTE: state registers use non-blocking assignments and sample reset on
    // the clock edge, so all flops update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            digit   <= '0;
        end else if (pre_cnt == LAST_CNT) begin
            pre_cnt <= '0;
            digit   <= (digit == LAST_DIGIT) ? '0 : digit + DIG_W'(1);
        end else begin
            pre_cnt <= pre_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame snapshot: the display reads only these, so inputs that change
    // mid-frame take effect at the next frame boundary.
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] snap_data;
    logic [DIGITS-1:0]   snap_dots;
    logic [DIGITS-1:0]   snap_blank;
    logic                snap_lzs;

    // NOTE: the snapshot is cleared on reset so that a reset mid-frame never
    // exposes stale contents before the fresh frame-start load.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_data  <= '0;
            snap_dots  <= '0;
            snap_blank <= '0;
            snap_lzs   <= 1'b0;
        end else if (frame_start) begin
            snap_data  <= data;
            snap_dots  <= dots;
            snap_blank <= blank;
            snap_lzs   <= lzs;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) frame_tick <= 1'b0;
        else       frame_tick <= frame_start;
    end

    // ------------------------------------------------------------------
    // Leading-zero mask: digit k>0 is suppressed when it and every more
    // significant digit are zero. Digit 0 is never suppressed.
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] suppress;
    logic              zero_above;

    always_comb begin
        suppress   = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zero_above  = zero_above && (snap_data[4*k +: 4] == 4'h0);
            suppress[k] = snap_lzs && zero_above;
        end
    end

    // ------------------------------------------------------------------
    // Current-digit select
    // ------------------------------------------------------------------
    logic [3:0] cur_nibble;
    logic       cur_dot;
    logic       cur_blank;
    logic       cur_supp;

    always_comb begin
        cur_nibble = '0;
        cur_dot    = 1'b0;
        cur_blank  = 1'b0;
        cur_supp   = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (digit == DIG_W'(k)) begin
                cur_nibble = snap_data[4*k +: 4];
                cur_dot    = snap_dots[k];
                cur_blank  = snap_blank[k];
                cur_supp   = suppress[k];
            end
        end
    end

    seg7_t hex_segs;

    seg_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .segs   (hex_segs)
    );

    // ------------------------------------------------------------------
    // PWM compare. pre_cnt==0 is always dark, giving a dead cycle between
    // digits so the previous digit's pattern never ghosts onto the next.
    // ------------------------------------------------------------------
    logic [LIM_W-1:0] on_limit;
    logic             lit;

    assign on_limit = ((LIM_W'(brightness) + LIM_W'(1)) * LIM_W'(CLK_DIV)) >> BRIGHT_W;
    assign lit      = (pre_cnt != '0) && (LIM_W'(pre_cnt) < on_limit);

    logic [7:0]        seg_on;
    logic [DIGITS-1:0] an_on;

    always_comb begin
        seg_on = '0;
        an_on  = '0;
        if (lit) begin
            an_on = DIGITS'(1) << digit;
            if (!cur_blank) begin
                seg_on[SEG_DP]    = cur_dot;
                seg_on[SEG_A:SEG_G] = cur_supp ? 7'h00 : hex_segs;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers, polarity applied here only.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= {8{POL}};
            an  <= {DIGITS{POL}};
        end else begin
            seg <= seg_on ^ {8{POL}};
            an  <= an_on ^ {DIGITS{POL}};
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_driver
//   Self-checking bench for seg_scan_driver (DIGITS=4, CLK_DIV=16, BRIGHT_W=4,
//   ACTIVE_LOW=1). The reference derives the display from the number of
//   clocks elapsed since reset release: slot position, digit and frame come
//   from plain division, and the glyph from a lookup table.
// ----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int D  = 4;
    localparam int CD = 16;
    localparam int BW = 4;
    localparam int FRAME = D * CD;

    logic            clk = 1'b0;
    logic            reset;
    logic [4*D-1:0]  data;
    logic [D-1:0]    dots;
    logic [D-1:0]    blank;
    logic            lzs;
    logic [BW-1:0]   brightness;
    logic [7:0]      seg;
    logic [D-1:0]    an;
    logic            frame_tick;

    seg_scan_driver #(
        .DIGITS     (D),
        .CLK_DIV    (CD),
        .BRIGHT_W   (BW),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .dots       (dots),
        .blank      (blank),
        .lzs        (lzs),
        .brightness (brightness),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Glyph table, a..g active-high.
    logic [6:0] hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference state
    int             n;          // clocks since reset release
    logic [4*D-1:0] m_data;
    logic [D-1:0]   m_dots;
    logic [D-1:0]   m_blank;
    logic           m_lzs;
    logic [7:0]     exp_seg;
    logic [D-1:0]   exp_an;
    logic           exp_tick;

    int tests = 0;
    int fails = 0;
    int lit_cycles;
    int tick_count;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs after one clock edge, from the inputs present at it.
    task automatic model_step();
        int pos, dig, hi, limit;
        logic [7:0] lit_seg;
        if (reset) begin
            n        = 0;
            m_data   = '0;
            m_dots   = '0;
            m_blank  = '0;
            m_lzs    = 1'b0;
            exp_seg  = 8'hFF;
            exp_an   = {D{1'b1}};
            exp_tick = 1'b0;
        end else begin
            pos = n % CD;
            dig = (n / CD) % D;
            exp_tick = (n % FRAME) == 0;
            if (exp_tick) begin
                m_data  = data;
                m_dots  = dots;
                m_blank = blank;
                m_lzs   = lzs;
            end
            hi = -1;
            for (int k = 0; k < D; k++)
                if (m_data[4*k +: 4] != 4'h0) hi = k;
            limit = ((int'(brightness) + 1) * CD) >> BW;
            if (pos >= 1 && pos < limit) begin
                lit_seg = 8'h00;
                if (!m_blank[dig]) begin
                    lit_seg[7]   = m_dots[dig];
                    lit_seg[6:0] = (m_lzs && dig > 0 && dig > hi) ? 7'h00 : hex_tab[m_data[4*dig +: 4]];
                end
                exp_seg = ~lit_seg;
                exp_an  = ~(D'(1) << dig);
            end else begin
                exp_seg = 8'hFF;
                exp_an  = {D{1'b1}};
            end
            n++;
        end
    endtask

    // One clock: edge, then compare on the following falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        model_step();
        check("seg", seg, exp_seg);
        check("an", 8'(an), 8'(exp_an));
        check("frame_tick", 8'(frame_tick), 8'(exp_tick));
        check("an_onehot", 8'($countones(~an) <= 1), 8'd1);
        if (an != {D{1'b1}}) lit_cycles++;
        if (frame_tick) tick_count++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    // Advance until the next edge is a frame start (bounded by one frame).
    task automatic align_frame();
        int guard = 0;
        while ((n % FRAME) != 0 && guard < 2 * FRAME) begin
            cycle();
            guard++;
        end
        check("align_bound", 8'(guard < 2 * FRAME), 8'd1);
    endtask

    initial begin
        reset      = 1'b1;
        data       = '0;
        dots       = '0;
        blank      = '0;
        lzs        = 1'b0;
        brightness = '1;
        lit_cycles = 0;
        tick_count = 0;
        n          = 0;
        @(negedge clk);

        // 1. Reset 3 clocks, then ticks every FRAME clocks.
        run(3);
        reset = 1'b0;
        tick_count = 0;
        run(2 * FRAME);
        check("tick_count_2frames", 8'(tick_count), 8'd2);

        // 2. Full brightness, 12AF, no suppression: 15 lit clocks per slot.
        data = 16'h12AF;
        align_frame();
        run(FRAME);     // frame that loads the new data
        lit_cycles = 0;
        run(FRAME);
        check("lit_full", 8'(lit_cycles), 8'(D * 15));

        // 3. Leading-zero suppression with a dot on the top digit, then all zero.
        data = 16'h0005;
        lzs  = 1'b1;
        dots = 4'b1000;
        run(2 * FRAME);
        data = 16'h0000;
        dots = 4'b0000;
        run(2 * FRAME);

        // 4. Brightness sweep: lit clocks per frame equal D*brightness.
        data = 16'h8888;
        lzs  = 1'b0;
        for (int b = 0; b < 16; b += 7) begin
            brightness = BW'(b);
            align_frame();
            lit_cycles = 0;
            run(FRAME);
            check("lit_per_frame", 8'(lit_cycles), 8'(D * b));
        end
        brightness = '1;

        // 5. Data change mid-frame must not tear.
        data = 16'h1111;
        align_frame();
        run(FRAME + 40);
        data = 16'h2222;
        run(2 * FRAME);

        // 6. Reset during digit 2, then a fresh frame from digit 0.
        data = 16'h3C5A;
        dots = 4'b0101;
        align_frame();
        run(2 * CD + 5);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        data  = 16'h9B7E;
        run(FRAME + 10);

        // Randomized phases.
        for (int it = 0; it < 40; it++) begin
            data       = 16'($urandom);
            if ($urandom_range(0, 2) == 0) data[15:8] = 8'h00;
            dots       = 4'($urandom);
            blank      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            lzs        = 1'($urandom);
            brightness = 4'($urandom);
            reset      = ($urandom_range(0, 9) == 0);
            cycle();
            reset = 1'b0;
            run($urandom_range(1, 90));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
